// File: rtl/ov5640_capture_if.sv
// Camera DVP bus and the captured byte stream toward the write FIFO.
// din_vld qualifies din for exactly one byte per cycle; there is no ready, so the sink must always accept.
interface ov5640_capture_if;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;
  logic [7:0] din;
  logic       din_vld;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  din, din_vld
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output din, din_vld
  );
endinterface

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: skips start-up frames, forwards whole frames as a byte stream
// and checks line/frame geometry. Single clock (pclk), synchronous active-high reset.
module ov5640_capture #(
  parameter int FRAME_SKIP      = 10,
  parameter int H_PIXELS        = 640,
  parameter int V_LINES         = 480,
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture_en,
  ov5640_capture_if.slave     bus,
  output logic                addr_write_clr,
  output logic                w_or_r_req,
  output logic                frame_done,
  output logic                line_err,
  output logic                frame_err,
  output logic [7:0]          frame_cnt,
  output logic [1:0]          dbg_state
);

  localparam int LINE_BYTES = H_PIXELS * BYTES_PER_PIXEL;
  localparam int BW = $clog2(LINE_BYTES + 1);
  localparam int LW = (V_LINES > 0) ? $clog2(V_LINES + 1) : 1;
  localparam int SW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam logic [BW-1:0] LINE_BYTES_C = BW'(LINE_BYTES);
  localparam logic [LW-1:0] V_LINES_C    = LW'(V_LINES);
  localparam logic [SW-1:0] SKIP_C       = SW'(FRAME_SKIP);

  typedef enum logic [1:0] {S_SKIP = 2'd0, S_WAIT = 2'd1, S_ACTIVE = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_vs_s1, r_vs_s2, r_href_s1, r_href_s2;
  logic [7:0]      r_data_s1, r_data_s2;
  logic [1:0]      r_fill;
  logic [SW-1:0]   r_skip_cnt;
  logic [BW-1:0]   r_byte_cnt;
  logic [LW-1:0]   r_line_cnt;
  logic            r_line_err, r_frame_err;
  logic            r_vld1, r_start1, r_end1;

  logic            w_vs_fall, w_vs_rise, w_href_fall;
  logic            w_start, w_end, w_skip_inc;
  logic            w_in_frame, w_byte, w_line_fall;
  logic [LW-1:0]   w_line_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_href_s1 <= 1'b0;
      r_href_s2 <= 1'b0;
      r_data_s1 <= 8'h00;
      r_data_s2 <= 8'h00;
      r_fill    <= 2'b00;
    end else begin
      r_vs_s1   <= bus.cam_vsync;
      r_vs_s2   <= r_vs_s1;
      r_href_s1 <= bus.cam_href;
      r_href_s2 <= r_href_s1;
      r_data_s1 <= bus.cam_data;
      r_data_s2 <= r_data_s1;
      r_fill    <= {r_fill[0], 1'b1};
    end
  end

  // Edges are masked until both sync stages hold real samples, so a bus that is
  // already in vsync when reset releases does not count as a frame end.
  assign w_vs_fall   = r_fill[1] &  r_vs_s2   & ~r_vs_s1;
  assign w_vs_rise   = r_fill[1] & ~r_vs_s2   &  r_vs_s1;
  assign w_href_fall = r_fill[1] &  r_href_s2 & ~r_href_s1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_SKIP;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_skip_inc  = 1'b0;
    case (r_state)
      S_SKIP: begin
        if (r_skip_cnt == SKIP_C) w_state_nxt = S_WAIT;
        else if (w_vs_rise)       w_skip_inc  = 1'b1;
      end
      S_WAIT: begin
        if (w_vs_fall && capture_en) begin
          w_state_nxt = S_ACTIVE;
          w_start     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_vs_rise) begin
          w_state_nxt = S_WAIT;
          w_end       = 1'b1;
        end
      end
      default: w_state_nxt = S_SKIP;
    endcase
  end

  // Frame start is folded into the in-frame test so a byte arriving with vsync fall is counted.
  assign w_in_frame  = (r_state == S_ACTIVE) | w_start;
  assign w_byte      = w_in_frame & r_href_s1;
  assign w_line_fall = (r_state == S_ACTIVE) & w_href_fall;
  assign w_line_nxt  = (w_line_fall && (r_line_cnt != '1)) ? r_line_cnt + 1'b1 : r_line_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_line_cnt  <= '0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_vld1      <= 1'b0;
      r_start1    <= 1'b0;
      r_end1      <= 1'b0;
    end else begin
      r_vld1   <= w_byte;
      r_start1 <= w_start;
      r_end1   <= w_end;
      if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 1'b1;
      if (w_start) begin
        r_byte_cnt <= w_byte ? BW'(1) : '0;
        r_line_cnt <= '0;
      end else begin
        if (w_line_fall) begin
          if (r_byte_cnt != LINE_BYTES_C) r_line_err <= 1'b1;
          r_byte_cnt <= '0;
        end else if (w_byte && (r_byte_cnt != '1)) begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
        r_line_cnt <= w_line_nxt;
      end
      if (w_end && (w_line_nxt != V_LINES_C)) r_frame_err <= 1'b1;
    end
  end

  // Output stage: everything leaves here, keeping data, pulses and flags aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.din        <= 8'h00;
      bus.din_vld    <= 1'b0;
      addr_write_clr <= 1'b0;
      w_or_r_req     <= 1'b0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
      frame_err      <= 1'b0;
      frame_cnt      <= 8'h00;
    end else begin
      bus.din_vld    <= r_vld1;
      if (r_vld1) bus.din <= r_data_s2;
      addr_write_clr <= r_start1;
      w_or_r_req     <= (r_state == S_ACTIVE);
      frame_done     <= r_end1;
      line_err       <= r_line_err;
      frame_err      <= r_frame_err;
      if (r_end1) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_ov5640_capture.sv
// Scoreboard bench for ov5640_capture: directed frames push timestamped expectations,
// a negedge monitor pops and compares whenever the DUT presents an output event.
module tb_ov5640_capture;

  localparam int W = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b1;
  logic        addr_write_clr, w_or_r_req, frame_done, line_err, frame_err;
  logic [7:0]  frame_cnt;
  logic [1:0]  dbg_state;
  logic [31:0] cyc = 32'd0;

  ov5640_capture_if bus();

  ov5640_capture #(
    .FRAME_SKIP(2), .H_PIXELS(4), .V_LINES(3), .BYTES_PER_PIXEL(2)
  ) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .bus(bus),
    .addr_write_clr(addr_write_clr), .w_or_r_req(w_or_r_req),
    .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [31:0]  clr_q[$];
  logic [32:0]  req_q[$];
  logic [41:0]  done_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   m_cnt = 8'd0;
  logic         m_lerr = 1'b0, m_ferr = 1'b0, f_bad = 1'b0;
  int           f_lines = 0;
  logic         req_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic empty_pop(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected DUT event at cycle %0d", name, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    if (bus.din_vld === 1'b1) begin
      if (exp_q.size() == 0) empty_pop("din");
      else check("din", {24'd0, cyc, bus.din}, {24'd0, exp_q.pop_front()});
    end
    if (addr_write_clr === 1'b1) begin
      if (clr_q.size() == 0) empty_pop("addr_write_clr");
      else check("addr_write_clr", {32'd0, cyc}, {32'd0, clr_q.pop_front()});
    end
    if (w_or_r_req !== req_prev) begin
      if (req_q.size() == 0) empty_pop("w_or_r_req");
      else check("w_or_r_req", {31'd0, cyc, w_or_r_req}, {31'd0, req_q.pop_front()});
      req_prev = w_or_r_req;
    end
    if (frame_done === 1'b1) begin
      if (done_q.size() == 0) empty_pop("frame_done");
      else check("frame_done", {22'd0, cyc, frame_cnt, frame_err, line_err},
                 {22'd0, done_q.pop_front()});
    end
  end

  // driver tasks
  task automatic vs_fall_t(input bit cap);
    @(negedge clk);
    bus.cam_vsync = 1'b0;
    f_lines = 0;
    f_bad   = 1'b0;
    if (cap) begin
      clr_q.push_back(cyc + 32'd3);
      req_q.push_back({cyc + 32'd3, 1'b1});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [7:0] base, input bit cap);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      bus.cam_href = 1'b1;
      bus.cam_data = base + 8'(b);
      if (cap) exp_q.push_back({cyc + 32'd3, bus.cam_data});
    end
    @(negedge clk);
    bus.cam_href = 1'b0;
    bus.cam_data = 8'h00;
    if (cap) begin
      f_lines++;
      if (n != 8) f_bad = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic vs_rise_t(input bit cap);
    @(negedge clk);
    bus.cam_vsync = 1'b1;
    if (cap) begin
      m_cnt = m_cnt + 8'd1;
      if (f_lines != 3) m_ferr = 1'b1;
      if (f_bad) m_lerr = 1'b1;
      done_q.push_back({cyc + 32'd3, m_cnt, m_ferr, m_lerr});
      req_q.push_back({cyc + 32'd3, 1'b0});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input bit cap, input int nlines, input int short_idx);
    vs_fall_t(cap);
    for (int l = 0; l < nlines; l++) send_line((l == short_idx) ? 7 : 8, 8'(l * 16), cap);
    vs_rise_t(cap);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cam_href = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outs", {57'd0, bus.din_vld, addr_write_clr, w_or_r_req, frame_done,
                       line_err, frame_err, dbg_state == 2'd0},
          {57'd0, 7'b0000001});
    check("rst_din", {56'd0, bus.din}, 64'd0);
    check("rst_cnt", {56'd0, frame_cnt}, 64'd0);
    m_cnt  = 8'd0;
    m_lerr = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    bus.cam_vsync = 1'b1;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outs", {58'd0, bus.din_vld, addr_write_clr, w_or_r_req, frame_done,
                         line_err, frame_err}, 64'd0);
    check("reset_cnt", {56'd0, frame_cnt}, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // skip two frames, then capture two
    frame(1'b0, 3, -1);
    frame(1'b0, 3, -1);
    frame(1'b1, 3, -1);
    frame(1'b1, 3, -1);

    // short line, single-byte latency line, then a good frame with sticky line_err
    frame(1'b1, 3, 1);
    vs_fall_t(1'b1);
    send_line(1, 8'hA5, 1'b1);
    send_line(8, 8'h10, 1'b1);
    send_line(8, 8'h20, 1'b1);
    vs_rise_t(1'b1);
    frame(1'b1, 3, -1);

    // capture gating
    capture_en = 1'b0;
    frame(1'b0, 3, -1);
    capture_en = 1'b1;
    vs_fall_t(1'b1);
    send_line(8, 8'h00, 1'b1);
    capture_en = 1'b0;
    send_line(8, 8'h10, 1'b1);
    send_line(8, 8'h20, 1'b1);
    vs_rise_t(1'b1);
    frame(1'b0, 3, -1);
    capture_en = 1'b1;

    // idle reset clears sticky flags, then a frame missing a line
    pulse_reset();
    repeat (3) @(negedge clk);
    frame(1'b0, 3, -1);
    frame(1'b0, 3, -1);
    frame(1'b1, 2, -1);

    // reset after the 10th byte of a captured frame
    vs_fall_t(1'b1);
    send_line(8, 8'h00, 1'b1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.cam_href = 1'b1;
      bus.cam_data = 8'h10 + 8'(b);
      exp_q.push_back({cyc + 32'd3, bus.cam_data});
    end
    @(negedge clk);
    rst = 1'b1;
    bus.cam_href = 1'b0;
    begin
      logic [31:0] r_edge;
      r_edge = cyc + 32'd1;
      while (exp_q.size() > 0 && exp_q[$][W-1:8] >= r_edge) void'(exp_q.pop_back());
      req_q.push_back({r_edge, 1'b0});
    end
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", {58'd0, bus.din_vld, addr_write_clr, w_or_r_req, frame_done,
                          line_err, frame_err}, 64'd0);
    check("midrst_cnt", {56'd0, frame_cnt}, 64'd0);
    m_cnt  = 8'd0;
    m_lerr = 1'b0;
    m_ferr = 1'b0;
    send_line(8, 8'h20, 1'b0);
    vs_rise_t(1'b0);
    frame(1'b0, 3, -1);
    frame(1'b1, 3, -1);

    repeat (10) @(negedge clk);
    check("din_left", 64'(exp_q.size()), 64'd0);
    check("clr_left", 64'(clr_q.size()), 64'd0);
    check("req_left", 64'(req_q.size()), 64'd0);
    check("done_left", 64'(done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
